pl_reg_skid: RTL and testbench

PL_REG_SKID -- requirements
Module: pl_reg_skid

---
 rtl/pl_pkg.sv | 22 ++
 rtl/pl_sat_cnt.sv | 33 +++
 rtl/pl_reg_skid.sv | 179 +++++++++++++++++
 tb/tb_pl_reg_skid.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pl_pkg                                                     |
// | Purpose : Shared constants and types for the fetch/decode pipeline   |
// |           register with skid buffer.                                 |
// |           NOP_INSTR  - canonical RISC-V NOP (addi x0, x0, 0)         |
// |           pl_state_t - occupancy of the two-entry skid register      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package pl_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // EMPTY: no entry held; ONE: main entry valid; FULL: main and skid valid
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pl_state_t;

endpackage : pl_pkg
`default_nettype wire

// File: rtl/pl_sat_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pl_sat_cnt                                                 |
// | Purpose : Saturating up-counter; sticks at all-ones.                 |
// | Ports   : clk   - clock                                              |
// |           clear - synchronous clear (wins over inc)                  |
// |           inc   - add one when not yet saturated                     |
// |           count - current value, CNT_WIDTH bits                      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module pl_sat_cnt #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 clear,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);

   logic [CNT_WIDTH-1:0] r_count;

   always_ff @(posedge clk) begin
      if (clear) begin
         r_count <= '0;
      end else if (inc && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule : pl_sat_cnt
`default_nettype wire

// File: rtl/pl_reg_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : pl_reg_skid                                                |
// | Purpose : Fetch-to-decode pipeline register with a one-entry skid    |
// |           buffer. Full throughput, one-cycle latency, and in_ready   |
// |           comes from registered state only (no in->out comb path).   |
// | Ports   : clk, rst_n (sync, active-low), flush (sync)                |
// |           in_valid/in_ready, pc_f, pc_plus4_f, instr_f   (upstream)  |
// |           out_valid/out_ready, pc_d, pc_plus4_d, instr_d (downstream)|
// |           stall_cnt, flush_cnt (only with PL_REG_SKID_PERF_EN)       |
// | Macro   : PL_REG_SKID_PERF_EN adds saturating stall/flush counters.  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module pl_reg_skid
   import pl_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDRESS_WIDTH-1:0] pc_f,
   input  logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
   input  logic [DATA_WIDTH-1:0]    instr_f,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ADDRESS_WIDTH-1:0] pc_d,
   output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
   output logic [DATA_WIDTH-1:0]    instr_d
`ifdef PL_REG_SKID_PERF_EN
   ,
   output logic [CNT_WIDTH-1:0]     stall_cnt,
   output logic [CNT_WIDTH-1:0]     flush_cnt
`endif
);

   localparam logic [DATA_WIDTH-1:0] c_nop = DATA_WIDTH'(NOP_INSTR);

   pl_state_t                r_state, w_state_nxt;
   logic [ADDRESS_WIDTH-1:0] r_m_pc, r_m_pc4, r_s_pc, r_s_pc4;
   logic [ADDRESS_WIDTH-1:0] w_m_pc_nxt, w_m_pc4_nxt, w_s_pc_nxt, w_s_pc4_nxt;
   logic [DATA_WIDTH-1:0]    r_m_instr, r_s_instr;
   logic [DATA_WIDTH-1:0]    w_m_instr_nxt, w_s_instr_nxt;
   logic                     w_accept;
   logic                     w_fire;

   assign in_ready   = (r_state != FULL);
   assign out_valid  = (r_state != EMPTY);
   assign w_accept   = in_valid && in_ready && !flush;
   assign w_fire     = out_valid && out_ready;

   // Main entry drives the outputs directly. Whenever the main entry is not
   // valid it is held at zero PCs and a NOP, so no output mux is needed.
   assign pc_d       = r_m_pc;
   assign pc_plus4_d = r_m_pc4;
   assign instr_d    = r_m_instr;

   always_comb begin
      w_state_nxt   = r_state;
      w_m_pc_nxt    = r_m_pc;
      w_m_pc4_nxt   = r_m_pc4;
      w_m_instr_nxt = r_m_instr;
      w_s_pc_nxt    = r_s_pc;
      w_s_pc4_nxt   = r_s_pc4;
      w_s_instr_nxt = r_s_instr;

      if (flush) begin
         // A same-cycle fire is still consumed downstream; nothing to undo.
         w_state_nxt   = EMPTY;
         w_m_pc_nxt    = '0;
         w_m_pc4_nxt   = '0;
         w_m_instr_nxt = c_nop;
         w_s_pc_nxt    = '0;
         w_s_pc4_nxt   = '0;
         w_s_instr_nxt = c_nop;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  w_state_nxt   = ONE;
                  w_m_pc_nxt    = pc_f;
                  w_m_pc4_nxt   = pc_plus4_f;
                  w_m_instr_nxt = instr_f;
               end
            end
            ONE: begin
               if (w_accept && w_fire) begin
                  w_m_pc_nxt    = pc_f;
                  w_m_pc4_nxt   = pc_plus4_f;
                  w_m_instr_nxt = instr_f;
               end else if (w_accept) begin
                  // Downstream stalled: park the new entry in the skid slot.
                  w_state_nxt   = FULL;
                  w_s_pc_nxt    = pc_f;
                  w_s_pc4_nxt   = pc_plus4_f;
                  w_s_instr_nxt = instr_f;
               end else if (w_fire) begin
                  w_state_nxt   = EMPTY;
                  w_m_pc_nxt    = '0;
                  w_m_pc4_nxt   = '0;
                  w_m_instr_nxt = c_nop;
               end
            end
            FULL: begin
               if (w_fire) begin
                  w_state_nxt   = ONE;
                  w_m_pc_nxt    = r_s_pc;
                  w_m_pc4_nxt   = r_s_pc4;
                  w_m_instr_nxt = r_s_instr;
                  w_s_pc_nxt    = '0;
                  w_s_pc4_nxt   = '0;
                  w_s_instr_nxt = c_nop;
               end
            end
            default: begin
               w_state_nxt   = EMPTY;
               w_m_pc_nxt    = '0;
               w_m_pc4_nxt   = '0;
               w_m_instr_nxt = c_nop;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= EMPTY;
         r_m_pc    <= '0;
         r_m_pc4   <= '0;
         r_m_instr <= c_nop;
         r_s_pc    <= '0;
         r_s_pc4   <= '0;
         r_s_instr <= c_nop;
      end else begin
         r_state   <= w_state_nxt;
         r_m_pc    <= w_m_pc_nxt;
         r_m_pc4   <= w_m_pc4_nxt;
         r_m_instr <= w_m_instr_nxt;
         r_s_pc    <= w_s_pc_nxt;
         r_s_pc4   <= w_s_pc4_nxt;
         r_s_instr <= w_s_instr_nxt;
      end
   end

`ifdef PL_REG_SKID_PERF_EN
   logic w_cnt_clear;
   logic w_stall_inc;

   assign w_cnt_clear = !rst_n;
   assign w_stall_inc = out_valid && !out_ready;

   pl_sat_cnt #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_stall_cnt (
      .clk   (clk),
      .clear (w_cnt_clear),
      .inc   (w_stall_inc),
      .count (stall_cnt)
   );

   pl_sat_cnt #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_flush_cnt (
      .clk   (clk),
      .clear (w_cnt_clear),
      .inc   (flush),
      .count (flush_cnt)
   );
`else
   // Counters absent; CNT_WIDTH is kept only for a uniform parameter list.
   localparam int c_unused_cnt_width = CNT_WIDTH;
`endif

endmodule : pl_reg_skid
`default_nettype wire

// File: tb/tb_pl_reg_skid.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_pl_reg_skid                                             |
// | Purpose : Self-checking bench for pl_reg_skid. A queue model (at most|
// |           two entries) predicts outputs every cycle; directed        |
// |           scenarios pin literal values; random traffic follows.      |
// |           Counter checks are active with PL_REG_SKID_PERF_EN.        |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_pl_reg_skid;
   import pl_pkg::*;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int CW   = 16;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [AW-1:0] pc_f, pc_plus4_f, pc_d, pc_plus4_d;
   logic [DW-1:0] instr_f, instr_d;
`ifdef PL_REG_SKID_PERF_EN
   logic [CW-1:0] stall_cnt, flush_cnt;
`endif

   logic       sc_clear, sc_inc;
   logic [1:0] sc_count;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pl_reg_skid #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW),
      .CNT_WIDTH     (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .pc_f       (pc_f),
      .pc_plus4_f (pc_plus4_f),
      .instr_f    (instr_f),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .pc_d       (pc_d),
      .pc_plus4_d (pc_plus4_d),
      .instr_d    (instr_d)
`ifdef PL_REG_SKID_PERF_EN
      ,
      .stall_cnt  (stall_cnt),
      .flush_cnt  (flush_cnt)
`endif
   );

   pl_sat_cnt #(.CNT_WIDTH(2)) u_sat2 (
      .clk   (clk),
      .clear (sc_clear),
      .inc   (sc_inc),
      .count (sc_count)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic [AW-1:0] pc;
      logic [AW-1:0] pc4;
      logic [DW-1:0] instr;
   } ent_t;

   ent_t q[$];
   bit   cleared = 1'b1;   // outputs must show zero PCs (after reset/flush)
   int   m_stall = 0;
   int   m_flush = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         q.delete();
         cleared = 1'b1;
         m_stall = 0;
         m_flush = 0;
      end else begin
         bit fire, acc;
         if (q.size() != 0 && !out_ready && m_stall < CMAX) m_stall++;
         if (flush && m_flush < CMAX) m_flush++;
         if (flush) begin
            q.delete();
            cleared = 1'b1;
         end else begin
            fire = (q.size() != 0) && out_ready;
            acc  = in_valid && (q.size() < 2);
            if (fire) void'(q.pop_front());
            if (acc) q.push_back('{pc: pc_f, pc4: pc_plus4_f, instr: instr_f});
            if (q.size() != 0) cleared = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
      if (q.size() != 0) begin
         chk("pc_d",       64'(pc_d),       64'(q[0].pc));
         chk("pc_plus4_d", 64'(pc_plus4_d), 64'(q[0].pc4));
         chk("instr_d",    64'(instr_d),    64'(q[0].instr));
      end else begin
         chk("instr_d_nop", 64'(instr_d), 64'(NOP_INSTR));
         if (cleared) begin
            chk("pc_d_zero",       64'(pc_d),       64'd0);
            chk("pc_plus4_d_zero", 64'(pc_plus4_d), 64'd0);
         end
      end
`ifdef PL_REG_SKID_PERF_EN
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      chk("flush_cnt", 64'(flush_cnt), 64'(m_flush));
`endif
   end

   // ---------------- stimulus ----------------
   task automatic drive(input bit v, input logic [AW-1:0] pc, input logic [DW-1:0] ins);
      in_valid   = v;
      pc_f       = pc;
      pc_plus4_f = pc + 4;
      instr_f    = ins;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_in_ready"},  64'(in_ready),   64'd1);
      chk({tag, "_out_valid"}, 64'(out_valid),  64'd0);
      chk({tag, "_pc_d"},      64'(pc_d),       64'd0);
      chk({tag, "_pc4_d"},     64'(pc_plus4_d), 64'd0);
      chk({tag, "_instr_d"},   64'(instr_d),    64'h13);
`ifdef PL_REG_SKID_PERF_EN
      chk({tag, "_stall_cnt"}, 64'(stall_cnt),  64'd0);
      chk({tag, "_flush_cnt"}, 64'(flush_cnt),  64'd0);
`endif
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      sc_clear = 1'b1; sc_inc = 1'b0;
      drive(1'b0, '0, '0);
      @(negedge clk);
      @(negedge clk);
      check_reset_vals("reset");

      // single transfer, one-cycle latency
      rst_n = 1'b1; out_ready = 1'b1;
      drive(1'b1, 32'h100, 32'h0050_0093);
      @(negedge clk);
      chk("lat_out_valid", 64'(out_valid),  64'd1);
      chk("lat_pc_d",      64'(pc_d),       64'h100);
      chk("lat_pc4_d",     64'(pc_plus4_d), 64'h104);
      chk("lat_instr_d",   64'(instr_d),    64'h0050_0093);
      drive(1'b0, '0, '0);
      @(negedge clk);
      chk("drain_out_valid", 64'(out_valid), 64'd0);

      // back-to-back stream
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, AW'(i * 4), DW'(32'h0000_0113 + i));
         @(negedge clk);
         chk("stream_pc_d",     64'(pc_d),     64'(i * 4));
         chk("stream_in_ready", 64'(in_ready), 64'd1);
      end
      drive(1'b0, '0, '0);
      @(negedge clk);

      // stall fills the skid slot, then drains in order
      out_ready = 1'b0;
      drive(1'b1, 32'h10, 32'h0000_1013);
      @(negedge clk);
      chk("stall_pc_d_a", 64'(pc_d), 64'h10);
      drive(1'b1, 32'h14, 32'h0000_1413);
      @(negedge clk);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      chk("full_pc_d",     64'(pc_d),     64'h10);
      drive(1'b0, '0, '0);
      out_ready = 1'b1;
      @(negedge clk);
      chk("drain_pc_d_b",  64'(pc_d),      64'h14);
      chk("drain_valid_b", 64'(out_valid), 64'd1);
      @(negedge clk);
      chk("drain_empty",   64'(out_valid), 64'd0);

      // flush while full with a pending input
      out_ready = 1'b0;
      drive(1'b1, 32'h20, 32'h0000_2013);
      @(negedge clk);
      drive(1'b1, 32'h24, 32'h0000_2413);
      @(negedge clk);
      chk("pre_flush_full", 64'(in_ready), 64'd0);
      flush = 1'b1;
      drive(1'b1, 32'h28, 32'h0000_2813);
      @(negedge clk);
      flush = 1'b0;
      drive(1'b0, '0, '0);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      chk("flush_instr_d",   64'(instr_d),   64'h13);
      chk("flush_pc_d",      64'(pc_d),      64'd0);
      chk("flush_in_ready",  64'(in_ready),  64'd1);
      @(negedge clk);
      chk("flush_dropped",   64'(out_valid), 64'd0);

      // reset while full
      drive(1'b1, 32'h30, 32'h0000_3013);
      @(negedge clk);
      drive(1'b1, 32'h34, 32'h0000_3413);
      @(negedge clk);
      chk("pre_reset_full", 64'(in_ready), 64'd0);
      drive(1'b1, 32'h38, 32'h0000_3813);
      flush = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      check_reset_vals("midreset");
      rst_n = 1'b1;
      flush = 1'b0;
      drive(1'b0, '0, '0);

      // 3 stall cycles then 2 flush cycles
      drive(1'b1, 32'h40, 32'h0000_4013);
      @(negedge clk);
      drive(1'b0, '0, '0);
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      @(negedge clk);
      flush = 1'b0;
`ifdef PL_REG_SKID_PERF_EN
      chk("perf_stall_cnt", 64'(stall_cnt), 64'd3);
      chk("perf_flush_cnt", 64'(flush_cnt), 64'd2);
`endif

      // 2-bit saturating counter: 5 increments stop at 3
      chk("sat_clear", 64'(sc_count), 64'd0);
      sc_clear = 1'b0;
      sc_inc   = 1'b1;
      repeat (2) @(negedge clk);
      chk("sat_two", 64'(sc_count), 64'd2);
      repeat (3) @(negedge clk);
      chk("sat_max", 64'(sc_count), 64'd3);
      sc_inc = 1'b0;

      // random traffic with varying backpressure
      for (int i = 0; i < 3000; i++) begin
         int rdy_pct;
         rdy_pct   = (i / 500) % 2 == 0 ? 80 : 30;
         drive($urandom_range(0, 99) < 70, AW'($urandom), DW'($urandom));
         out_ready = $urandom_range(0, 99) < rdy_pct;
         flush     = $urandom_range(0, 39) == 0;
         rst_n     = $urandom_range(0, 199) != 0;
         @(negedge clk);
      end
      rst_n = 1'b1; flush = 1'b0;
      drive(1'b0, '0, '0);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pl_reg_skid
`default_nettype wire
